// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, header layout
// and the header assembly helper.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_CH_LSB   = 16;
    localparam int HDR_SEQ_LSB  = 8;
    localparam int HDR_RSVD_LSB = 0;

    function automatic logic [31:0] make_header(input logic [7:0] sync,
                                                input logic [7:0] ch,
                                                input logic [7:0] seq);
        logic [31:0] hdr;
        hdr                      = '0;
        hdr[HDR_SYNC_LSB +: 8]   = sync;
        hdr[HDR_CH_LSB   +: 8]   = ch;
        hdr[HDR_SEQ_LSB  +: 8]   = seq;
        hdr[HDR_RSVD_LSB +: 8]   = 8'h00;
        return hdr;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: returns the first set request strictly
// after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         valid_o
);

    int          idx;
    logic [W-1:0] idx_w;

    // Walk from the farthest candidate back to the nearest so the last hit,
    // i.e. the one closest after the pointer, wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) idx = idx - N;
            idx_w = idx[W-1:0];
            if (req_i[idx_w]) begin
                grant_o = idx_w;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter framing per-channel FIFO bursts behind a sync/seq
// header toward a single 32-bit serializer.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         MAX_BURST = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [32*NUM_CH-1:0]  ch_data,
    input  logic [NUM_CH-1:0]     ch_valid,
    output logic [NUM_CH-1:0]     ch_rd_en,
    input  logic [NUM_CH-1:0]     ch_enable,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_rd_en,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    localparam int CH_W = $clog2(NUM_CH);

    state_e            state_q;
    logic [2:0]        grant_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [7:0]        seq_q [NUM_CH];
    logic [7:0]        burst_cnt_q;
    logic [7:0]        burst_cnt_d;
    logic [31:0]       hold_q;

    logic [31:0]       ch_word [NUM_CH];
    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_valid;
    logic              consume;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_word[g] = ch_data[32*g +: 32];
    end

    assign req         = ch_valid & ch_enable;
    assign grant_idx   = grant_q[CH_W-1:0];
    assign consume     = out_valid & out_rd_en;
    assign burst_cnt_d = burst_cnt_q + 8'd1;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;

    rr_pick #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_idx),
        .valid_o (pick_valid)
    );

    // Data words pass straight through so the serializer sees FWFT timing.
    always_comb begin
        out_valid = 1'b0;
        out_data  = hold_q;
        ch_rd_en  = '0;
        case (state_q)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = make_header(SYNC_BYTE, 8'(grant_q), seq_q[grant_idx]);
            end
            ST_BURST: begin
                out_valid           = ch_valid[grant_idx];
                out_data            = ch_word[grant_idx];
                ch_rd_en[grant_idx] = out_rd_en & ch_valid[grant_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            burst_cnt_q <= '0;
            hold_q      <= '0;
            // NOTE: the sequence counters are architectural state, so each entry is reset explicitly rather than left as uninitialised storage.
            for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (out_valid) hold_q <= out_data;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q  <= 3'(pick_idx);
                        rr_ptr_q <= pick_idx;
                        state_q  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (consume) begin
                        seq_q[grant_idx] <= seq_q[grant_idx] + 8'd1;
                        burst_cnt_q      <= '0;
                        state_q          <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (consume) begin
                        burst_cnt_q <= burst_cnt_d;
                        if (burst_cnt_d == 8'(MAX_BURST)) state_q <= ST_IDLE;
                    end else if (!ch_valid[grant_idx]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of 32-bit requester channels (2..8).
REQ-003 Parameter MAX_BURST, default 8, SHALL set the maximum data words per grant (1..255).
REQ-004 Parameter SYNC_BYTE, default 8'hA5, SHALL set header bits [31:24].
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ch_data  in  32*NUM_CH  per-channel FWFT FIFO head word; channel i at [32*i+31:32*i].
REQ-008 ch_valid  in  NUM_CH  per-channel FIFO not-empty.
REQ-009 ch_rd_en  out  NUM_CH  per-channel one-cycle read pulse (pops head word).
REQ-010 ch_enable  in  NUM_CH  per-channel arbitration enable (quasi-static config).
REQ-011 out_data  out  32  word presented to the 32-bit byte serializer.
REQ-012 out_valid  out  1  out_data valid (FWFT semantics toward serializer).
REQ-013 out_rd_en  in  1  serializer pop pulse; word consumed when out_rd_en and out_valid are both high.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 grant_id  out  3  index of the channel currently or last granted.

Function
REQ-016 FSM SHALL have states IDLE, HDR, BURST.
REQ-017 IDLE: when (ch_valid & ch_enable) is non-zero, the block SHALL grant the first eligible channel searching round-robin from (last grant + 1) mod NUM_CH and move to HDR on the next edge; otherwise it SHALL stay in IDLE.
REQ-018 The first arbitration after reset SHALL search from channel 0.
REQ-019 HDR: out_valid=1 and out_data = {SYNC_BYTE, 8'(grant_id), seq[grant_id], 8'h00}; on a consume the block SHALL increment seq[grant_id] (8-bit, 255 wraps to 0), clear burst_cnt and go to BURST.
REQ-020 BURST: out_data = ch_data[grant], out_valid = ch_valid[grant], ch_rd_en[grant] = out_rd_en & out_valid (combinational pass-through, zero latency); all other ch_rd_en SHALL be 0.
REQ-021 BURST: each consume SHALL increment burst_cnt; the consume that makes burst_cnt equal MAX_BURST SHALL return the FSM to IDLE.
REQ-022 BURST: if ch_valid[grant] is low in a cycle, the burst SHALL end and the FSM SHALL return to IDLE on the next edge; the next header SHALL therefore be followed by at least one data word only if the source refills first.
REQ-023 ch_enable deassertion for the granted channel SHALL NOT truncate a burst in progress; it SHALL take effect at the next arbitration.
REQ-024 out_rd_en while out_valid=0 SHALL be ignored; ch_rd_en SHALL never pulse outside BURST.
REQ-025 In IDLE, out_valid SHALL be 0 and out_data SHALL hold its last value.
REQ-026 A channel whose ch_valid rises in the same cycle another channel is granted SHALL wait for the next arbitration, with no lost or duplicated words.

Reset
REQ-027 While rst_n=0: state=IDLE, out_valid=0, out_data=0, ch_rd_en=0, busy=0, grant_id=0, all seq=0, burst_cnt=0, round-robin pointer=NUM_CH-1.
REQ-028 Reset asserted mid-burst SHALL abort immediately with no further ch_rd_en pulse; words already popped are not replayed.

Structure
REQ-029 Header field positions, SYNC_BYTE default and FSM state encodings SHALL live in the shared package uart_tx_pkg.
REQ-030 The round-robin priority search SHALL be a sub-module rr_pick (request vector, pointer in; grant index and grant-valid out, combinational).
REQ-031 Implementation SHALL be 120-400 lines, with no inferred latches.

Verification
REQ-032 Single channel: ch1 holds 3 words 0x11111111..0x33333333, MAX_BURST=8 -> out stream A5_01_00_00, 11111111, 22222222, 33333333; then IDLE, busy=0.
REQ-033 Burst limit: ch0 holds 10 words, MAX_BURST=8 -> header seq 0 + 8 words, then header A5_00_01_00 + 2 words.
REQ-034 Round-robin fairness: all 4 channels continuously valid -> header order ch0, ch1, ch2, ch3, ch0 with 8 words each.
REQ-035 Enable mask: ch_enable=4'b1010, all channels valid -> only ch1 and ch3 granted, alternating; ch0/ch2 ch_rd_en never pulse.
REQ-036 Sequence wrap: 256 single-word bursts on ch2 -> header seq byte runs 0..255, then 0.
REQ-037 Reset mid-burst: rst_n low after 3 of 8 words -> ch_rd_en=0 and out_valid=0 within the reset cycle; the first header after release carries seq 0 and arbitration starts from channel 0.
